// File: rtl/myproject_mul_share_sched.sv
// myproject_mul_share_sched
//   Round-robin scheduler that time-shares one external 18s x 17ns -> 26
//   multiplier between NUM_REQ requesters. The winning operand pair is
//   registered (S1) onto the multiplier inputs. The combinational product is
//   registered (S2) together with the requester index. S2 drives a single
//   valid/ready response channel.
// Ports
//   ap_clk, ap_rst_n          clock (rising edge), async active-low reset
//   req_valid/req_ready       per-requester handshake; req_ready is one-hot or zero
//   req_a, req_b              packed operands, requester i at [i*W +: W]
//   mul_din0, mul_din1        registered operands to the multiplier
//   mul_dout                  combinational product from the multiplier
//   rsp_valid/rsp_ready       response handshake
//   rsp_p, rsp_id             product and index of the requester that issued it
module myproject_mul_share_sched #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2,
    parameter int A_WIDTH  = 18,
    parameter int B_WIDTH  = 17,
    parameter int P_WIDTH  = 26
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic [A_WIDTH-1:0]           mul_din0,
    output logic [B_WIDTH-1:0]           mul_din1,
    input  logic [P_WIDTH-1:0]           mul_dout,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [P_WIDTH-1:0]           rsp_p,
    output logic [ID_WIDTH-1:0]          rsp_id
);

    localparam int unsigned N = NUM_REQ;

    logic                s1_valid;
    logic [ID_WIDTH-1:0] s1_id;
    logic                s2_valid;
    logic [P_WIDTH-1:0]  s2_p;
    logic [ID_WIDTH-1:0] s2_id;
    logic [ID_WIDTH-1:0] ptr;
    // Cleared by reset and set on the first edge after release, so req_ready
    // stays low while reset is held and through the release edge.
    logic                run;

    logic                adv1;
    logic                adv2;
    logic                found;
    logic                xfer;
    logic [ID_WIDTH-1:0] grant;
    logic [A_WIDTH-1:0]  sel_a;
    logic [B_WIDTH-1:0]  sel_b;

    assign adv2 = !s2_valid || rsp_ready;
    assign adv1 = !s1_valid || adv2;

    // Rotating-priority scan starting at ptr; the first valid requester wins.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        grant = '0;
        sel_a = '0;
        sel_b = '0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = idx[ID_WIDTH-1:0];
                sel_a = req_a[idx*A_WIDTH +: A_WIDTH];
                sel_b = req_b[idx*B_WIDTH +: B_WIDTH];
            end
        end
    end

    assign xfer = run && adv1 && found;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            run      <= 1'b0;
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_id    <= '0;
            mul_din0 <= '0;
            mul_din1 <= '0;
            s2_valid <= 1'b0;
            s2_p     <= '0;
            s2_id    <= '0;
        end else begin
            run <= 1'b1;

            if (xfer) begin
                s1_valid <= 1'b1;
                s1_id    <= grant;
                mul_din0 <= sel_a;
                mul_din1 <= sel_b;
                if (grant == ID_WIDTH'(NUM_REQ - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= grant + 1'b1;
                end
            end else if (adv1) begin
                s1_valid <= 1'b0;
            end

            if (adv2) begin
                if (s1_valid) begin
                    s2_valid <= 1'b1;
                    s2_p     <= mul_dout;
                    s2_id    <= s1_id;
                end else begin
                    s2_valid <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_p     = s2_p;
    assign rsp_id    = s2_id;

endmodule

// File: tb/tb_myproject_mul_share_sched.sv
// Directed bench for myproject_mul_share_sched. It includes a behavioural model
// of the shared 18s x 17ns -> 26 multiplier. All expected values are hand-computed.
module tb_myproject_mul_share_sched;

    localparam int NUM_REQ  = 4;
    localparam int ID_WIDTH = 2;
    localparam int A_WIDTH  = 18;
    localparam int B_WIDTH  = 17;
    localparam int P_WIDTH  = 26;

    logic                       ap_clk;
    logic                       ap_rst_n;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*A_WIDTH-1:0] req_a;
    logic [NUM_REQ*B_WIDTH-1:0] req_b;
    logic [A_WIDTH-1:0]         mul_din0;
    logic [B_WIDTH-1:0]         mul_din1;
    logic [P_WIDTH-1:0]         mul_dout;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [P_WIDTH-1:0]         rsp_p;
    logic [ID_WIDTH-1:0]        rsp_id;

    logic signed [A_WIDTH-1:0]  ta [NUM_REQ];
    logic        [B_WIDTH-1:0]  tb [NUM_REQ];
    logic signed [35:0]         prod_full;

    int errors = 0;
    int checks = 0;

    myproject_mul_share_sched #(
        .NUM_REQ (NUM_REQ),
        .ID_WIDTH(ID_WIDTH),
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH),
        .P_WIDTH (P_WIDTH)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .mul_din0 (mul_din0),
        .mul_din1 (mul_din1),
        .mul_dout (mul_dout),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_p    (rsp_p),
        .rsp_id   (rsp_id)
    );

    // Shared multiplier: signed din0 times zero-extended din1, low 26 bits.
    assign prod_full = $signed(mul_din0) * $signed({1'b0, mul_din1});
    assign mul_dout  = prod_full[P_WIDTH-1:0];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*A_WIDTH +: A_WIDTH] = ta[i];
            req_b[i*B_WIDTH +: B_WIDTH] = tb[i];
        end
    end

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        ap_rst_n  = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            ta[i] = '0;
            tb[i] = '0;
        end

        // Reset state
        tick(); tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_p",     32'(rsp_p),     32'd0);
        chk("rst_rsp_id",    32'(rsp_id),    32'd0);
        chk("rst_din0",      32'(mul_din0),  32'd0);
        #2 ap_rst_n = 1'b1;
        tick();

        // 1: req1 3*5, two-edge latency
        ta[1] = 18'sd3; tb[1] = 17'd5;
        req_valid = 4'b0010;
        #1 chk("t1_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        chk("t1_din0",       32'(mul_din0),  32'd3);
        chk("t1_valid_e1",   32'(rsp_valid), 32'd0);
        tick();
        chk("t1_valid_e2",   32'(rsp_valid), 32'd1);
        chk("t1_p",          32'(rsp_p),     32'd15);
        chk("t1_id",         32'(rsp_id),    32'd1);
        tick();
        chk("t1_valid_done", 32'(rsp_valid), 32'd0);

        // 2: negative and wrapping products; ptr is 2
        ta[0] = -18'sd2;      tb[0] = 17'd7;
        ta[2] = -18'sd131072; tb[2] = 17'd131071;
        req_valid = 4'b0101;
        #1 chk("t2_ready_a", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0001;
        #1 chk("t2_ready_b", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        chk("t2_id_a", 32'(rsp_id), 32'd2);
        chk("t2_p_a",  32'(rsp_p),  32'h0020000);
        tick();
        chk("t2_id_b", 32'(rsp_id), 32'd0);
        chk("t2_p_b",  32'(rsp_p),  32'h3FFFFF2);
        tick();
        chk("t2_done", 32'(rsp_valid), 32'd0);

        // 5: req3 alone, then req0+req3 (ptr wraps to 0 after the req3 grant)
        ta[3] = 18'sd10; tb[3] = 17'd10;
        req_valid = 4'b1000;
        #1 chk("t5_ready_3", 32'(req_ready), 32'b1000);
        tick();
        req_valid = 4'b1001;
        #1 chk("t5_ready_0", 32'(req_ready), 32'b0001);
        tick();
        chk("t5_rsp_id_3", 32'(rsp_id), 32'd3);
        chk("t5_rsp_p_3",  32'(rsp_p),  32'd100);
        chk("t5_ready_3b", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        chk("t5_rsp_id_0", 32'(rsp_id), 32'd0);
        chk("t5_rsp_p_0",  32'(rsp_p),  32'h3FFFFF2);
        tick();
        chk("t5_rsp_id_3b", 32'(rsp_id), 32'd3);
        tick();
        chk("t5_done", 32'(rsp_valid), 32'd0);

        // 3: all requesters valid, ptr=0 -> grants 0,1,2,3,0,1
        for (int i = 0; i < NUM_REQ; i++) begin
            ta[i] = 18'(i + 1);
            tb[i] = 17'd100;
        end
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            #1 chk("t3_ready", 32'(req_ready), 32'(1) << (i % 4));
            tick();
            if (i >= 1) begin
                chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("t3_rsp_id",    32'(rsp_id),    32'((i - 1) % 4));
                chk("t3_rsp_p",     32'(rsp_p),     32'((((i - 1) % 4) + 1) * 100));
            end
        end
        req_valid = '0;
        tick();
        chk("t3_last_id", 32'(rsp_id), 32'd1);
        chk("t3_last_p",  32'(rsp_p),  32'd200);
        tick();
        chk("t3_done", 32'(rsp_valid), 32'd0);

        // 4: backpressure with both stages full; ptr is 2
        req_valid = 4'b1111;
        #1 chk("t4_ready_2", 32'(req_ready), 32'b0100);
        tick();
        chk("t4_ready_3", 32'(req_ready), 32'b1000);
        rsp_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t4_hold_id",    32'(rsp_id),    32'd2);
            chk("t4_hold_p",     32'(rsp_p),     32'd300);
            chk("t4_hold_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1 chk("t4_ready_rel", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        chk("t4_rel_id_3", 32'(rsp_id), 32'd3);
        chk("t4_rel_p_3",  32'(rsp_p),  32'd400);
        tick();
        chk("t4_rel_id_0", 32'(rsp_id), 32'd0);
        chk("t4_rel_p_0",  32'(rsp_p),  32'd100);
        tick();
        chk("t4_done", 32'(rsp_valid), 32'd0);

        // 6: asynchronous reset mid-stream
        req_valid = 4'b1111;
        tick(); tick();
        chk("t6_pre_valid", 32'(rsp_valid), 32'd1);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
        chk("t6_rst_ready", 32'(req_ready), 32'd0);
        #2 ap_rst_n = 1'b1;
        tick();
        chk("t6_first_grant", 32'(req_ready), 32'b0001);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        chk("t6_no_replay", 32'(rsp_valid), 32'd0);
        tick();
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t6_rsp_id",    32'(rsp_id),    32'd0);
        chk("t6_rsp_p",     32'(rsp_p),     32'd100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
